// File: rtl/spi_frame_pkg.sv
// Shared types and frame geometry for the MySPI 32-bit register frame initiator.
package spi_frame_pkg;

  localparam int FRAME_BITS = 32;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 16;
  localparam int WRITE_BIT  = 31;

  typedef enum logic [2:0] {
    S_Idle,
    S_Setup,
    S_Low,
    S_High,
    S_Hold,
    S_Gap
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic theClock,
  input  logic theReset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 initiator issuing one 32-bit {W, ADDR, DATA} MySPI frame per accepted request,
// with a one-cycle response pulse carrying the 16 data bits shifted in.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_GAP      = 4
) (
  input  logic              theClock,
  input  logic              theReset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_clk,
  output logic              spi_cs,
  output logic              spi_sdo,
  input  logic              spi_sdi
);

  localparam int TMR_W = $clog2(max3(HALF_PERIOD, CS_SETUP, CS_GAP)) + 1;

  localparam logic [TMR_W-1:0] HP_LAST    = TMR_W'(HALF_PERIOD - 1);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 1);
  localparam logic [4:0]       LAST_BIT   = 5'(FRAME_BITS - 1);

  // Below these limits the slave's SCLK synchronizer cannot follow the frame.
  if (HALF_PERIOD < 4 || CS_SETUP < 3 || CS_GAP < 2) begin : g_param_check
    $error("spi_frame_master: HALF_PERIOD>=4, CS_SETUP>=3, CS_GAP>=2 required");
  end

  state_t                  state;
  logic [TMR_W-1:0]        timer;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   tx;
  logic [DATA_W-1:0]       rx;
  logic                    sdi_s;

  sync_2ff u_sdi_sync (
    .theClock (theClock),
    .theReset (theReset),
    .d        (spi_sdi),
    .q        (sdi_s)
  );

  assign req_ready = (state == S_Idle);

  // NOTE: every register here, including the shift registers, is reset so that an abort
  // mid-frame leaves no stale bits visible on the pins or in the next response.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      state     <= S_Idle;
      timer     <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      spi_cs    <= 1'b1;
      spi_clk   <= 1'b0;
      spi_sdo   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge values of tx/rx/timer.
      rsp_valid <= 1'b0;
      case (state)
        S_Idle: begin
          if (req_valid) begin
            tx      <= {req_write, req_addr, req_write ? req_wdata : DATA_W'(0)};
            spi_sdo <= req_write;
            spi_cs  <= 1'b0;
            spi_clk <= 1'b0;
            bit_cnt <= '0;
            timer   <= SETUP_LAST;
            state   <= S_Setup;
          end
        end

        S_Setup: begin
          if (timer == '0) begin
            timer <= HP_LAST;
            state <= S_Low;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_Low: begin
          if (timer == '0) begin
            spi_clk <= 1'b1;
            timer   <= HP_LAST;
            state   <= S_High;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_High: begin
          // Only the data phase returns meaningful MISO bits; the synchronizer has settled by now.
          if (timer == HP_LAST && bit_cnt[4]) begin
            rx <= {rx[DATA_W-2:0], sdi_s};
          end
          if (timer == '0) begin
            spi_clk <= 1'b0;
            tx      <= {tx[FRAME_BITS-2:0], 1'b0};
            spi_sdo <= tx[WRITE_BIT-1];
            bit_cnt <= bit_cnt + 1'b1;
            timer   <= HP_LAST;
            state   <= (bit_cnt == LAST_BIT) ? S_Hold : S_Low;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_Hold: begin
          if (timer == '0) begin
            spi_cs    <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx;
            timer     <= GAP_LAST;
            state     <= S_Gap;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_Gap: begin
          if (timer == '0) begin
            state <= S_Idle;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: state <= S_Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed plus randomized checks of spi_frame_master against a MySPI-style slave model.
module tb_spi_frame_master;

  localparam int HP        = 4;
  localparam int SETUP     = 4;
  localparam int GAP       = 4;
  localparam int CS_LOW    = SETUP + 64 * HP + HP;
  localparam int RSP_LAT   = 1 + SETUP + 65 * HP;
  localparam int BUSY_CYC  = RSP_LAT + GAP;

  logic        theClock = 1'b0;
  logic        theReset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [14:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_sdo;
  logic        spi_sdi = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 theClock = ~theClock;

  spi_frame_master #(
    .HALF_PERIOD (HP),
    .CS_SETUP    (SETUP),
    .CS_GAP      (GAP)
  ) dut (
    .theClock  (theClock),
    .theReset  (theReset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .spi_sdo   (spi_sdo),
    .spi_sdi   (spi_sdi)
  );

  // ---------------- slave model: register file loaded at address, committed at CS rise
  logic [15:0] slave_mem [0:32767];
  logic [15:0] ref_mem   [0:32767];
  int          s_n = 0;
  logic [31:0] s_shift = '0;
  logic [15:0] s_rd = '0;
  logic [31:0] frame_q [$];
  int          abort_cnt = 0;

  always @(posedge spi_clk or posedge spi_cs) begin
    if (spi_cs) begin
      if (s_n == 32) begin
        frame_q.push_back(s_shift);
        if (s_shift[31]) slave_mem[s_shift[30:16]] = s_shift[15:0];
      end else if (s_n != 0) begin
        abort_cnt = abort_cnt + 1;
      end
      s_n <= 0;
    end else begin
      if (s_n == 15) s_rd <= slave_mem[{s_shift[13:0], spi_sdo}];
      s_shift <= {s_shift[30:0], spi_sdo};
      s_n     <= s_n + 1;
    end
  end

  always @(negedge spi_clk) begin
    if (!spi_cs && s_n >= 16 && s_n < 32) spi_sdi <= s_rd[31 - s_n];
  end

  // ---------------- pin monitor, sampled on the inactive clock edge
  int   ncyc = 0;
  int   acc_m = -100000;
  int   cs_run = 0;
  int   rises = 0;
  int   per_bad = 0;
  int   last_rise = 0;
  int   ready_bad = 0;
  logic prev_cs = 1'b1;
  logic prev_clk = 1'b0;
  int   acc_q [$];
  int   fall_q [$];
  int   rise_q [$];
  int   cslow_q [$];
  int   rises_q [$];
  int   perbad_q [$];
  int   lat_q [$];
  logic [15:0] rsp_q [$];

  always @(negedge theClock) begin
    ncyc     <= ncyc + 1;
    prev_cs  <= spi_cs;
    prev_clk <= spi_clk;
    if (theReset) begin
      acc_m <= -100000;
    end else if (req_valid && req_ready) begin
      acc_m <= ncyc;
      acc_q.push_back(ncyc);
    end
    if (!theReset && req_ready && (ncyc > acc_m) && (ncyc - acc_m < BUSY_CYC))
      ready_bad <= ready_bad + 1;
    if (prev_cs && !spi_cs) begin
      cs_run  <= 1;
      rises   <= 0;
      per_bad <= 0;
      fall_q.push_back(ncyc);
    end else if (!spi_cs) begin
      cs_run <= cs_run + 1;
    end
    if (!prev_cs && spi_cs) begin
      rise_q.push_back(ncyc);
      cslow_q.push_back(cs_run);
      rises_q.push_back(rises);
      perbad_q.push_back(per_bad);
    end
    if (spi_clk && !prev_clk) begin
      rises <= rises + 1;
      if (rises > 0 && (ncyc - last_rise) != 2 * HP) per_bad <= per_bad + 1;
      last_rise <= ncyc;
    end
    if (rsp_valid) begin
      rsp_q.push_back(rsp_rdata);
      lat_q.push_back(ncyc - acc_m);
    end
  end

  // ---------------- helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic clear_queues();
    frame_q.delete(); acc_q.delete(); fall_q.delete(); rise_q.delete();
    cslow_q.delete(); rises_q.delete(); perbad_q.delete(); lat_q.delete(); rsp_q.delete();
  endtask

  task automatic wait_accept(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * BUSY_CYC && !ok; i++) begin
      @(negedge theClock);
      if (req_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge theClock);
      #1;
    end else begin
      timeout(tag);
    end
  endtask

  task automatic wait_rsp(input string tag, input int count);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * BUSY_CYC && !ok; i++) begin
      @(posedge theClock);
      #1;
      if (rsp_q.size() >= count) ok = 1'b1;
    end
    if (!ok) timeout(tag);
    repeat (GAP + 2) @(posedge theClock);
    #1;
  endtask

  // Pops one completed frame's observations and compares them to the expected frame.
  task automatic check_frame(input string tag, input logic [31:0] exp_frame, input logic [15:0] exp_rd);
    check({tag, " mosi_frames"}, 32'(frame_q.size() > 0), 32'd1);
    if (frame_q.size() > 0) check({tag, " mosi"}, frame_q.pop_front(), exp_frame);
    check({tag, " rsp_pulses"}, 32'(rsp_q.size() > 0), 32'd1);
    if (rsp_q.size() > 0) check({tag, " rdata"}, 32'(rsp_q.pop_front()), 32'(exp_rd));
    if (lat_q.size() > 0) check({tag, " rsp_latency"}, 32'(lat_q.pop_front()), 32'(RSP_LAT));
    if (cslow_q.size() > 0) check({tag, " cs_low_cycles"}, 32'(cslow_q.pop_front()), 32'(CS_LOW));
    if (rises_q.size() > 0) check({tag, " sclk_rises"}, 32'(rises_q.pop_front()), 32'd32);
    if (perbad_q.size() > 0) check({tag, " sclk_period_errs"}, 32'(perbad_q.pop_front()), 32'd0);
  endtask

  task automatic txn(input string tag, input logic w, input logic [14:0] a, input logic [15:0] d);
    logic [31:0] exp_frame;
    logic [15:0] exp_rd;
    exp_frame = {w, a, w ? d : 16'h0000};
    exp_rd    = ref_mem[a];
    if (w) ref_mem[a] = d;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    wait_accept({tag, " accept"});
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 15'($urandom);
    req_wdata = 16'($urandom);
    wait_rsp({tag, " rsp"}, 1);
    check({tag, " rsp_count"}, 32'(rsp_q.size()), 32'd1);
    check_frame(tag, exp_frame, exp_rd);
    acc_q.delete(); fall_q.delete(); rise_q.delete();
  endtask

  // ---------------- stimulus
  initial begin
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    int          aborts_before;

    for (int i = 0; i < 32768; i++) begin
      slave_mem[i] = 16'h0000;
      ref_mem[i]   = 16'h0000;
    end
    slave_mem[1] = 16'h00A5;
    ref_mem[1]   = 16'h00A5;

    repeat (3) @(posedge theClock);
    #1;
    check("reset spi_cs", 32'(spi_cs), 32'd1);
    check("reset spi_clk", 32'(spi_clk), 32'd0);
    check("reset spi_sdo", 32'(spi_sdo), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    theReset = 1'b0;
    repeat (2) @(posedge theClock);
    #1;

    txn("read01", 1'b0, 15'h0001, 16'h0000);
    txn("write10", 1'b1, 15'h0010, 16'h1234);
    txn("read10", 1'b0, 15'h0010, 16'hFFFF);

    for (int i = 0; i < 10; i++) begin
      logic        w;
      logic [14:0] a;
      int          sel;
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 15'h7FFF : (sel == 1) ? 15'h0010 : (sel == 2) ? 15'h0003 : 15'($urandom);
      txn($sformatf("rand%0d", i), w, a, (i == 0) ? 16'hFFFF : 16'($urandom));
    end

    // Two requests with req_valid held high throughout.
    clear_queues();
    exp_a = {1'b1, 15'h0020, 16'hCAFE};
    rd_a  = ref_mem[15'h0020];
    ref_mem[15'h0020] = 16'hCAFE;
    exp_b = {1'b0, 15'h0020, 16'h0000};
    rd_b  = ref_mem[15'h0020];
    req_write = 1'b1;
    req_addr  = 15'h0020;
    req_wdata = 16'hCAFE;
    req_valid = 1'b1;
    wait_accept("b2b accept A");
    req_write = 1'b0;
    req_wdata = 16'h5555;
    wait_accept("b2b accept B");
    req_valid = 1'b0;
    wait_rsp("b2b rsp", 2);
    check("b2b accepts", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() >= 2) check("b2b accept spacing", 32'(acc_q[1] - acc_q[0]), 32'(BUSY_CYC));
    if (fall_q.size() >= 2 && rise_q.size() >= 1)
      check("b2b cs gap", 32'(fall_q[1] - rise_q[0]), 32'(GAP + 1));
    check("b2b ready while busy", 32'(ready_bad), 32'd0);
    check("b2b rsp count", 32'(rsp_q.size()), 32'd2);
    check_frame("b2b A", exp_a, rd_a);
    check_frame("b2b B", exp_b, rd_b);
    clear_queues();

    // Reset while address bit 10 is on the wire.
    aborts_before = abort_cnt;
    req_write = 1'b1;
    req_addr  = 15'h0000;
    req_wdata = 16'hBEEF;
    req_valid = 1'b1;
    wait_accept("abort accept");
    req_valid = 1'b0;
    for (int i = 0; i < 200 && s_n < 5; i++) @(posedge theClock);
    repeat (HP + 1) @(posedge theClock);
    #1;
    check("abort cs low before reset", 32'(spi_cs), 32'd0);
    theReset = 1'b1;
    #1;
    check("abort spi_cs", 32'(spi_cs), 32'd1);
    check("abort spi_clk", 32'(spi_clk), 32'd0);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(posedge theClock);
    #1;
    theReset = 1'b0;
    repeat (20) @(posedge theClock);
    #1;
    check("abort slave aborts", 32'(abort_cnt - aborts_before), 32'd1);
    check("abort no frame", 32'(frame_q.size()), 32'd0);
    check("abort no rsp", 32'(rsp_q.size()), 32'd0);
    check("abort rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("abort reg unchanged", 32'(slave_mem[0]), 32'(ref_mem[0]));
    clear_queues();

    txn("post-reset read00", 1'b0, 15'h0000, 16'h0000);
    txn("config write", 1'b1, 15'h0000, 16'h005A);
    txn("config read", 1'b0, 15'h0000, 16'h0000);
    check("config readback reg", 32'(slave_mem[0]), 32'h005A);
    check("final ready_bad", 32'(ready_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
